// File: rtl/mpy_pkg.sv
// Shared widths, FSM state encoding and operand layout for the multiplier issue stage.
package mpy_pkg;

  localparam int OP_W            = 32;
  localparam int P_W             = 64;
  localparam int TAG_W           = 2;
  localparam int TIMEOUT_DEFAULT = 40;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    HOLD
  } mpy_issue_state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } opnd_t;

endpackage

// File: rtl/mpy_opnd_fifo.sv
// Operand FIFO: synchronous, head visible combinationally, pop frees the head on the edge.
// Backpressure: full is exported; a push while full is only taken if a pop happens in the same cycle.
module mpy_opnd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // The extra MSB tells a full FIFO apart from an empty one when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/mpy_issue.sv
// Issues buffered operand pairs to a sequential multiplier and holds each product until res_ready.
// Start pulse one cycle after a push into an idle block; MPY_ISSUE_TIMEOUT_EN adds a WAIT timeout.
module mpy_issue
  import mpy_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             mpy_start,
  output logic [OP_W-1:0]  mpy_a,
  output logic [OP_W-1:0]  mpy_b,
  input  logic [P_W-1:0]   mpy_p,
  input  logic             mpy_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [P_W-1:0]   res_p,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err
);

  mpy_issue_state_t state;
  opnd_t            head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [TAG_W-1:0] tag_cnt;
  logic             wait_armed;

  assign in_ready = !fifo_full;
  assign fifo_pop = (state == START);

  mpy_opnd_fifo #(.DEPTH(DEPTH), .W(2*OP_W)) u_fifo (
    .CLK      (CLK),
    .reset    (reset),
    .push     (in_valid && in_ready),
    .push_dat ({in_a, in_b}),
    .pop      (fifo_pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef MPY_ISSUE_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       timed_out;
  assign timed_out = (wait_cnt == 8'(TIMEOUT - 1));
`else
  // Without the timeout feature the error flag is constant zero.
  assign res_err = (TIMEOUT < 0);
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      mpy_start  <= 1'b0;
      mpy_a      <= '0;
      mpy_b      <= '0;
      res_valid  <= 1'b0;
      res_p      <= '0;
      res_tag    <= '0;
      tag_cnt    <= '0;
      wait_armed <= 1'b0;
`ifdef MPY_ISSUE_TIMEOUT_EN
      res_err    <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      mpy_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state     <= START;
            mpy_start <= 1'b1;
            mpy_a     <= head.a;
            mpy_b     <= head.b;
            res_tag   <= tag_cnt;
          end
        end
        START: begin
          state      <= WAIT;
          wait_armed <= 1'b0;
`ifdef MPY_ISSUE_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
        end
        WAIT: begin
          // The multiplier's out_valid may still be stale in the first WAIT cycle.
          wait_armed <= 1'b1;
          if (wait_armed && mpy_valid) begin
            res_p     <= mpy_p;
            res_valid <= 1'b1;
            state     <= HOLD;
`ifdef MPY_ISSUE_TIMEOUT_EN
            res_err   <= 1'b0;
          end else if (timed_out) begin
            res_p     <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            wait_cnt  <= wait_cnt + 8'd1;
`endif
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            tag_cnt   <= tag_cnt + TAG_W'(1);
            if (!fifo_empty) begin
              state     <= START;
              mpy_start <= 1'b1;
              mpy_a     <= head.a;
              mpy_b     <= head.b;
              res_tag   <= tag_cnt + TAG_W'(1);
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpy_issue.sv
// Scoreboard bench for mpy_issue with a behavioural sequential multiplier of random latency.
module tb_mpy_issue;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        mpy_start;
  logic [31:0] mpy_a;
  logic [31:0] mpy_b;
  logic [63:0] mpy_p;
  logic        mpy_valid;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_p;
  logic [1:0]  res_tag;
  logic        res_err;

  mpy_issue #(.DEPTH(4), .TIMEOUT(40)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mpy_start (mpy_start),
    .mpy_a     (mpy_a),
    .mpy_b     (mpy_b),
    .mpy_p     (mpy_p),
    .mpy_valid (mpy_valid),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .res_tag   (res_tag),
    .res_err   (res_err)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] p;
    logic [1:0]  tag;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot = 0;
  int   push_idx = 0;
  int   rr_mode = 0;
  bit   stall = 1'b0;

  function automatic logic [63:0] mul(input logic [31:0] a, input logic [31:0] b);
    longint x;
    longint y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  // Behavioural multiplier: out_valid and product stay stale for one cycle after a start.
  logic [31:0] ma, mb;
  logic        mv = 1'b0;
  logic [63:0] mp = '0;
  int          mcnt = 0;
  bit          mbusy = 1'b0;
  bit          mclr = 1'b0;
  assign mpy_valid = mv;
  assign mpy_p     = mp;

  always @(posedge CLK) begin
    if (reset) begin
      mv <= 1'b0; mp <= '0; mbusy <= 1'b0; mclr <= 1'b0; mcnt <= 0;
    end else if (mpy_start) begin
      mbusy <= 1'b1; mclr <= 1'b1; mcnt <= $urandom_range(0, 5);
      ma <= mpy_a; mb <= mpy_b;
    end else begin
      if (mclr) begin mv <= 1'b0; mclr <= 1'b0; end
      if (mbusy && !stall) begin
        if (mcnt == 0) begin mv <= 1'b1; mp <= mul(ma, mb); mbusy <= 1'b0; end
        else mcnt <= mcnt - 1;
      end
    end
  end

  initial forever begin
    @(posedge CLK); #1;
    case (rr_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = 1'b0;
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: result comparison, hold stability and back-to-back issue.
  bit          stab_pend = 1'b0;
  bit          exp_start = 1'b0;
  logic [63:0] sp;
  logic [1:0]  st;
  logic        se;
  int          pushed_n = 0;
  int          done_n = 0;
  exp_t        e_mon;

  always @(negedge CLK) begin
    if (reset) begin
      stab_pend = 1'b0; exp_start = 1'b0; pushed_n = 0; done_n = 0;
    end else begin
      if (stab_pend)
        chk("hold_stable", {res_valid, res_p, res_tag, res_err}, {1'b1, sp, st, se});
      if (exp_start) chk("no_bubble", mpy_start, 1);
      exp_start = 1'b0;
      if (res_valid && res_ready) begin
        chk("result_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e_mon = sb.pop_front();
          chk("res_p", res_p, e_mon.p);
          chk("res_tag", res_tag, e_mon.tag);
          chk("res_err", res_err, e_mon.err);
        end
        exp_start = (pushed_n - done_n - 1) > 0;
        done_n++;
      end
      if (in_valid && in_ready) pushed_n++;
      stab_pend = res_valid && !res_ready;
      sp = res_p; st = res_tag; se = res_err;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] p, input logic err);
    int n = 0;
    while (!in_ready && n < 300) begin step(1); n++; end
    if (!in_ready) begin
      chk("push_wait", in_ready, 1);
    end else begin
      in_a = a; in_b = b; in_valid = 1'b1;
      sb.push_back('{p: p, tag: 2'(push_idx), err: err});
      push_idx++;
      step(1);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    sb.delete();
    push_idx = 0;
  endtask

  task automatic reset_vals(input string tg);
    chk({tg, "_in_ready"}, in_ready, 1);
    chk({tg, "_mpy_start"}, mpy_start, 0);
    chk({tg, "_mpy_ab"}, {mpy_a, mpy_b}, 0);
    chk({tg, "_res_valid"}, res_valid, 0);
    chk({tg, "_res_p"}, res_p, 0);
    chk({tg, "_res_tag"}, res_tag, 0);
    chk({tg, "_res_err"}, res_err, 0);
  endtask

  task automatic drain(input string tg);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin step(1); n++; end
    chk({tg, "_drain"}, sb.size(), 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int n;
    int seen;
    logic [31:0] ra, rb;

    step(2);
    reset = 1'b0;
    reset_vals("rst");

    // Positive x positive, with issue latency.
    rr_mode = 0;
    push(32'd30, 32'd90, 64'd2700, 1'b0);
    @(negedge CLK); chk("issue_early", mpy_start, 0);
    @(negedge CLK); chk("issue_pulse", mpy_start, 1);
    chk("issue_ab", {mpy_a, mpy_b}, {32'd30, 32'd90});
    @(negedge CLK); chk("pulse_width", mpy_start, 0);
    @(posedge CLK); #1;
    drain("pos");

    // Signed combinations issued back-to-back.
    push(32'd30, -32'sd90, 64'hFFFF_FFFF_FFFF_F574, 1'b0);
    push(-32'sd30, 32'd90, 64'hFFFF_FFFF_FFFF_F574, 1'b0);
    push(-32'sd30, -32'sd90, 64'd2700, 1'b0);
    drain("signed");

    // Extreme operands.
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0);
    push(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    drain("extreme");

    // Full FIFO with downstream stalled.
    do_reset();
    rr_mode = 1;
    step(1);
    for (int i = 0; i < 5; i++) push(32'(i + 1), 32'(i + 11), 64'((i + 1) * (i + 11)), 1'b0);
    chk("full_in_ready", in_ready, 0);
    acc = 0;
    in_a = 32'd6; in_b = 32'd16; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) acc++;
      step(1);
    end
    in_valid = 1'b0;
    chk("full_no_accept", acc, 0);
    rr_mode = 2;
    push(32'd6, 32'd16, 64'd96, 1'b0);
    drain("full");

`ifdef MPY_ISSUE_TIMEOUT_EN
    // Multiplier never answers: the result must time out after 40 WAIT cycles.
    rr_mode = 0;
    stall = 1'b1;
    push(32'd3, 32'd4, 64'd0, 1'b1);
    n = 0;
    do begin @(negedge CLK); n++; end while (!mpy_start && n < 20);
    n = 0;
    do begin @(negedge CLK); n++; end while (!res_valid && n < 100);
    chk("timeout_cycles", n, 41);
    stall = 1'b0;
    @(posedge CLK); #1;
    push(32'd6, 32'd7, 64'd42, 1'b0);
    drain("timeout");
`endif

    // Reset during WAIT with two pairs still queued.
    do_reset();
    rr_mode = 0;
    stall = 1'b1;
    push(32'd2, 32'd3, 64'd6, 1'b0);
    push(32'd4, 32'd5, 64'd20, 1'b0);
    push(32'd6, 32'd7, 64'd42, 1'b0);
    step(3);
    do_reset();
    reset_vals("midrst");
    stall = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid) seen++;
      step(1);
    end
    chk("no_stale", seen, 0);
    push(32'd5, 32'd7, 64'd35, 1'b0);
    drain("post_reset");

    // Randomized traffic with random backpressure.
    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      ra = pick();
      rb = pick();
      push(ra, rb, mul(ra, rb), 1'b0);
      step($urandom_range(0, 3));
    end
    drain("random");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
